// File: rtl/md_unit_if.sv
// Handshake and result bus between the E-stage control and the mul/div unit.
// The pipeline drives the master side; md_unit sits on the slave side.
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, cancel, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, cancel, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed at acceptance, then held back for a fixed latency.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);
  localparam logic [2:0] OP_MTHI  = 3'b001;
  localparam logic [2:0] OP_MTLO  = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_DIV   = 3'b110;

  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic [WIDTH-1:0] tmp_hi;
  logic [WIDTH-1:0] tmp_lo;
  logic             tmp_wr;

  logic [2*WIDTH-1:0] prod_u;
  logic [2*WIDTH-1:0] prod_s;
  logic               is_signed_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Signed division runs on magnitudes so the most-negative / -1 case wraps
  // naturally to most-negative with a zero remainder.
  always_comb begin
    prod_u        = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    prod_s        = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    is_signed_div = (bus.md_op == OP_DIV);
    a_neg         = is_signed_div && bus.a[WIDTH-1];
    b_neg         = is_signed_div && bus.b[WIDTH-1];
    mag_a         = a_neg ? (~bus.a + 1'b1) : bus.a;
    mag_b         = b_neg ? (~bus.b + 1'b1) : bus.b;
    if (mag_b == '0) begin
      mag_b = {{(WIDTH-1){1'b0}}, 1'b1};
    end
    q_mag         = mag_a / mag_b;
    r_mag         = mag_a % mag_b;
    quo           = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    rem           = a_neg ? (~r_mag + 1'b1) : r_mag;
  end

  // Control FSM; tmp_wr is cleared for divide-by-zero so HI/LO are left alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      tmp_hi   <= '0;
      tmp_lo   <= '0;
      tmp_wr   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (bus.md_op)
              OP_MTHI: bus.hi <= bus.a;
              OP_MTLO: bus.lo <= bus.a;
              OP_MULTU, OP_MULT: begin
                {tmp_hi, tmp_lo} <= (bus.md_op == OP_MULT) ? prod_s : prod_u;
                tmp_wr           <= 1'b1;
                cnt              <= MUL_CNT;
                bus.busy         <= 1'b1;
                state            <= RUN;
              end
              OP_DIVU, OP_DIV: begin
                tmp_hi   <= rem;
                tmp_lo   <= quo;
                tmp_wr   <= (bus.b != '0);
                cnt      <= DIV_CNT;
                bus.busy <= 1'b1;
                state    <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt == 8'd0) begin
            if (tmp_wr) begin
              bus.hi <= tmp_hi;
              bus.lo <= tmp_lo;
            end
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, multi-cycle corner
// sequences, and random operations checked against an arithmetic model.
module tb_md_unit;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_MTHI = 3'b001;
  localparam logic [2:0] OP_MTLO = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_NOP7 = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  vec_t vecs[10];

  md_unit_if #(.WIDTH(WIDTH)) bus ();

  md_unit #(
    .WIDTH  (WIDTH),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cancel, inout logic [31:0] h, inout logic [31:0] l,
                           output int lat);
    longint unsigned up;
    longint          sp, sa, sb, q, r;
    lat = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    if (!cancel) begin
      case (op)
        OP_MTHI: h = a;
        OP_MTLO: l = a;
        OP_MULU: begin
          up  = longint'({32'b0, a}) * longint'({32'b0, b});
          h   = up[63:32];
          l   = up[31:0];
          lat = MUL_LAT;
        end
        OP_MUL: begin
          sp  = sa * sb;
          h   = sp[63:32];
          l   = sp[31:0];
          lat = MUL_LAT;
        end
        OP_DIVU: begin
          lat = DIV_LAT;
          if (b != 0) begin
            l = a / b;
            h = a % b;
          end
        end
        OP_DIV: begin
          lat = DIV_LAT;
          if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.a      = a;
    bus.b      = b;
    bus.cancel = cancel;
  endtask

  task automatic release_inputs();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.md_op  = 3'($urandom_range(0, 7));
    bus.a      = $urandom;
    bus.b      = $urandom;
  endtask

  // Entered #1 after the accepting edge; watches the busy window then the done pulse.
  task automatic finish_op(input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_lat,
                           input logic [31:0] old_hi, input logic [31:0] old_lo);
    int n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      check("done_low_in_run", 64'(bus.done), 64'(0));
      check("hi_stable_in_run", 64'(bus.hi), 64'(old_hi));
      check("lo_stable_in_run", 64'(bus.lo), 64'(old_lo));
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_cycles", 64'(n), 64'(exp_lat));
    check("done_pulse", 64'(bus.done), 64'(exp_lat > 0));
    check("hi_result", 64'(bus.hi), 64'(exp_hi));
    check("lo_result", 64'(bus.lo), 64'(exp_lo));
    @(posedge clk);
    #1;
    check("done_single_cycle", 64'(bus.done), 64'(0));
  endtask

  task automatic apply_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cancel, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat);
    logic [31:0] old_hi = m_hi;
    logic [31:0] old_lo = m_lo;
    drive(op, a, b, cancel);
    @(posedge clk);
    #1;
    release_inputs();
    finish_op(exp_hi, exp_lo, exp_lat, old_hi, old_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    logic [31:0] ra, rb, nh, nl;
    logic [2:0]  rop;
    logic        rc;
    int          rlat, n;

    vecs[0] = '{OP_MUL,  32'hFFFFFFFD, 32'd5,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{OP_MULU, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{OP_DIVU, 32'd7,        32'd2,        1'b0, 32'd1,        32'd3,        10};
    vecs[4] = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{OP_MTHI, 32'h12345678, 32'h0,        1'b0, 32'h12345678, 32'h80000000, 0};
    vecs[6] = '{OP_MTLO, 32'h0000ABCD, 32'h0,        1'b0, 32'h12345678, 32'h0000ABCD, 0};
    vecs[7] = '{OP_MUL,  32'd3,        32'd4,        1'b1, 32'h12345678, 32'h0000ABCD, 0};
    vecs[8] = '{OP_DIVU, 32'd55,       32'd0,        1'b0, 32'h12345678, 32'h0000ABCD, 10};
    vecs[9] = '{OP_NOP7, 32'hDEADBEEF, 32'd9,        1'b0, 32'h12345678, 32'h0000ABCD, 0};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.md_op  = OP_NOP;
    bus.a      = '0;
    bus.b      = '0;
    #12;
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_hi", 64'(bus.hi), 64'(0));
    check("reset_lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      apply_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cancel, vecs[i].hi, vecs[i].lo, vecs[i].lat);
    end

    // DIVU in flight; a MULT presented at busy cycle 3 must be ignored.
    drive(OP_DIVU, 32'd100, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    release_inputs();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.md_op = OP_MUL;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    @(posedge clk);
    #1;
    release_inputs();
    finish_op(32'd2, 32'd14, DIV_LAT - 3, m_hi, m_lo);
    m_hi = 32'd2;
    m_lo = 32'd14;

    // Back-to-back: a start in the done cycle is accepted.
    drive(OP_MULU, 32'd10, 32'd10, 1'b0);
    @(posedge clk);
    #1;
    release_inputs();
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b_first_cycles", 64'(n), 64'(MUL_LAT));
    check("b2b_first_done", 64'(bus.done), 64'(1));
    check("b2b_first_lo", 64'(bus.lo), 64'(100));
    bus.start = 1'b1;
    bus.md_op = OP_DIVU;
    bus.a     = 32'd50;
    bus.b     = 32'd6;
    @(posedge clk);
    #1;
    release_inputs();
    finish_op(32'd2, 32'd8, DIV_LAT, 32'd0, 32'd100);
    m_hi = 32'd2;
    m_lo = 32'd8;

    // Reset at busy cycle 2 of a MULT, then accept on the first edge after release.
    drive(OP_MUL, 32'd5, 32'd6, 1'b0);
    @(posedge clk);
    #1;
    release_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'(0));
    check("midrst_done", 64'(bus.done), 64'(0));
    check("midrst_hi", 64'(bus.hi), 64'(0));
    check("midrst_lo", 64'(bus.lo), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.md_op = OP_MULU;
    bus.a     = 32'd6;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    release_inputs();
    check("post_reset_accept", 64'(bus.busy), 64'(1));
    finish_op(32'd0, 32'd42, MUL_LAT, 32'd0, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd42;

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      rc = ($urandom_range(0, 7) == 0);
      nh = m_hi;
      nl = m_lo;
      ref_model(rop, ra, rb, rc, nh, nl, rlat);
      apply_op(rop, ra, rb, rc, nh, nl, rlat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width.
REQ-002 SHALL have parameter MUL_LAT, default 5: multiply busy cycles, legal range 1..255.
REQ-003 SHALL have parameter DIV_LAT, default 10: divide busy cycles, legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: the E-stage instruction is a mul/div-class instruction.
REQ-007 SHALL have port md_op, input, 3 bits: 001 MTHI, 010 MTLO, 011 MULTU, 100 MULT, 101 DIVU, 110 DIV; 000 and 111 are no-op.
REQ-008 SHALL have port cancel, input, 1 bit: exception or interrupt on the E-stage instruction; suppresses that cycle's start.
REQ-009 SHALL have port a, input, WIDTH bits: rs operand.
REQ-010 SHALL have port b, input, WIDTH bits: rt operand.
REQ-011 SHALL have port busy, output, 1 bit: an operation is in progress (registered).
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse in the cycle HI/LO take a new result.
REQ-013 SHALL have port hi, output, WIDTH bits: the HI register.
REQ-014 SHALL have port lo, output, WIDTH bits: the LO register.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and RUN, plus a down-counter 8 bits wide.
REQ-016 SHALL accept an operation only when start=1, cancel=0, and state=IDLE; the accepting edge is edge E0.
REQ-017 SHALL ignore start entirely when state=RUN; the external hazard unit stalls on (start & busy).
REQ-018 SHALL, for MTHI or MTLO accepted at E0, write a into hi or lo at E0, leave the FSM in IDLE, and not pulse done.
REQ-019 SHALL, for MULT, MULTU, DIV or DIVU accepted at E0:
- compute the 2*WIDTH result into internal temp registers at E0;
- enter RUN;
- load the counter with LAT-1, where LAT is MUL_LAT for MULT/MULTU and DIV_LAT for DIV/DIVU.
REQ-020 SHALL, in RUN:
- decrement the counter each edge;
- on the edge where counter=0, write the temp registers into hi/lo, return to IDLE, and set done=1 for the following cycle.
REQ-021 SHALL hold busy high for exactly LAT cycles, starting the cycle after E0.
REQ-022 SHALL set hi/lo for MULTU to the unsigned 2*WIDTH product: hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-023 SHALL set hi/lo for MULT to the two's-complement signed product, split the same way as MULTU.
REQ-024 SHALL, for DIV/DIVU, set lo to the quotient and hi to the remainder.
REQ-025 SHALL truncate the signed DIV quotient toward zero, with the remainder taking the sign of the dividend.
REQ-026 SHALL, for signed overflow (a = most-negative, b = -1), produce lo = most-negative and hi = 0.
REQ-027 SHALL, on divide by zero (b=0), still run the full DIV_LAT cycles and pulse done, but leave hi and lo unchanged.
REQ-028 SHALL keep hi/lo stable throughout RUN; hi/lo change only at E0 (MTHI/MTLO) or at completion.
REQ-029 SHALL let cancel have no effect while in RUN; an accepted operation always completes.
REQ-030 SHALL treat md_op 000/111 with start=1 as no change.
REQ-031 SHALL ignore a and b except at the accepting edge.
REQ-032 SHALL allow back-to-back operation: a start presented in the cycle done=1 (state IDLE) is accepted.

Reset
REQ-033 SHALL, while reset=1, asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and temp registers=0.
REQ-034 SHALL, on reset asserted mid-RUN, discard the operation; hi/lo read 0 and no done pulse follows.
REQ-035 SHALL accept a new start on the first rising edge after reset deasserts.

Verification
REQ-036 SHALL verify MULT: a=0xFFFFFFFD, b=5 -> busy high for 5 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 SHALL verify MULTU: a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-038 SHALL verify DIV and DIVU:
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF;
- DIVU a=7, b=2 -> lo=3, hi=1.
REQ-039 SHALL verify busy-start and overflow:
- start DIVU; issue MULT at busy cycle 3 -> ignored; hi/lo reflect only the DIVU result;
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 SHALL verify MTHI/cancel and divide-by-zero:
- MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy stays 0;
- MULT with cancel=1 -> busy stays 0, hi/lo unchanged;
- DIVU b=0 -> done after 10 cycles, hi/lo unchanged.
REQ-041 SHALL verify reset mid-operation: assert reset at busy cycle 2 of MULT -> busy=0, hi=lo=0 immediately; no done pulse follows.
